// File: rtl/add_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_share_pkg
// Brief    : Shared types and default sizes for the add_share_arb block.
// Revision : 1.0
// ============================================================================
package add_share_pkg;

  localparam int c_N_REQ = 4;
  localparam int c_W     = 8;
  localparam int c_IDW   = $clog2(c_N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One pipeline slot; field widths follow the package defaults above.
  typedef struct packed {
    logic [c_IDW-1:0] id;
    logic [c_W-1:0]   data;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/add_share_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first valid index at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter
  import add_share_pkg::*;
#(
  parameter int N_REQ = c_N_REQ,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx
);

  localparam int c_CW = IDW + 1;

  logic [c_CW-1:0] w_cand;
  logic            w_found;

  // Walk the request vector starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, ptr} + c_CW'(k);
      if (w_cand >= c_CW'(N_REQ)) begin
        w_cand = w_cand - c_CW'(N_REQ);
      end
      if (!w_found && req[w_cand[IDW-1:0]]) begin
        w_found = 1'b1;
        idx     = w_cand[IDW-1:0];
      end
    end
  end

  assign grant = (w_found && advance) ? (N_REQ'(1) << idx) : '0;

endmodule
`default_nettype wire

// File: rtl/add_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : add_share_arb
// Brief    : Round-robin shared two-stage add/pass datapath with tagged
//            responses. Define ADD_SHARE_ARB_SAT_EN for saturating adds.
// Revision : 1.0
// ============================================================================
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int N_REQ = c_N_REQ,
  parameter int W     = c_W,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_op,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic               busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_s1_full;
  logic             r_s2_full;
  entry_t           r_s1;
  entry_t           r_s2;

  logic             w_s2_take;
  logic             w_advance;
  logic             w_xfer;
  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_idx;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W-1:0]     w_add;
  logic [W-1:0]     w_result;

  // Stage 2 can accept when it is empty or its entry leaves this cycle.
  assign w_s2_take = !r_s2_full || rsp_ready;
  assign w_advance = !r_s1_full || !r_s2_full || rsp_ready;
  assign w_req     = (r_state == RUN) ? req_valid : '0;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req     (w_req),
    .ptr     (r_rr_ptr),
    .advance (w_advance),
    .grant   (w_grant),
    .idx     (w_idx)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;
  assign w_a       = req_a[w_idx*W +: W];
  assign w_b       = req_b[w_idx*W +: W];

`ifdef ADD_SHARE_ARB_SAT_EN
  logic [W:0] w_sum;
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_add = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
`else
  assign w_add = w_a + w_b;
`endif

  assign w_result = req_op[w_idx] ? w_add : w_a;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (en) begin
          w_state_nxt = RUN;
        end else if (!r_s1_full && !r_s2_full) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_s1_full <= 1'b0;
      r_s2_full <= 1'b0;
      r_s1      <= '0;
      r_s2      <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_xfer) begin
        r_rr_ptr  <= (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + IDW'(1);
        r_s1_full <= 1'b1;
        r_s1.id   <= w_idx;
        r_s1.data <= w_result;
      end else if (w_s2_take) begin
        r_s1_full <= 1'b0;
      end

      // Stage 2 only reloads on a real entry so outputs hold otherwise.
      if (w_s2_take) begin
        r_s2_full <= r_s1_full;
        if (r_s1_full) begin
          r_s2 <= r_s1;
        end
      end
    end
  end

  assign rsp_valid = r_s2_full;
  assign rsp_id    = r_s2.id;
  assign rsp_data  = r_s2.data;
  assign busy      = (r_state != IDLE) || r_s1_full || r_s2_full;

endmodule
`default_nettype wire

// File: tb/tb_add_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_share_arb
// Brief    : Directed vector table plus hand sequences for add_share_arb.
// Revision : 1.0
// ============================================================================
module tb_add_share_arb;

  localparam int N = 4;
  localparam int W = 8;

`ifdef ADD_SHARE_ARB_SAT_EN
  localparam logic [7:0] c_E200P100 = 8'd255;
  localparam logic [7:0] c_E255P1   = 8'd255;
`else
  localparam logic [7:0] c_E200P100 = 8'd44;
  localparam logic [7:0] c_E255P1   = 8'd0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;

  always #5 clk = ~clk;

  add_share_arb dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    int         id;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic op, input logic [7:0] a, input logic [7:0] b);
    req_op[id]        = op;
    req_a[id*W +: W]  = a;
    req_b[id*W +: W]  = b;
  endtask

  function automatic logic [7:0] rr_data(input int i);
    return 8'(11 * i + 1);
  endfunction

  function automatic logic [31:0] rsp_word(input int id, input logic [7:0] d);
    return 32'({1'b1, 2'(id), d});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       got;
    logic [7:0] held_data;
    logic [1:0] held_id;
    int         ngr;

    tbl[0] = '{2, 1'b1, 8'd3,   8'd4,   8'd7};
    tbl[1] = '{0, 1'b1, 8'd200, 8'd100, c_E200P100};
    tbl[2] = '{1, 1'b0, 8'd200, 8'd55,  8'd200};
    tbl[3] = '{3, 1'b1, 8'd255, 8'd1,   c_E255P1};
    tbl[4] = '{0, 1'b0, 8'd0,   8'd9,   8'd0};
    tbl[5] = '{3, 1'b1, 8'd17,  8'd25,  8'd42};

    rst = 1'b1; en = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;
    held_data = '0; held_id = '0; ngr = 0;
    step(); step();
    check("reset_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);

    rst = 1'b0; en = 1'b1;
    step();

    // Table: one request at a time, exact two-cycle latency.
    for (int v = 0; v < 6; v++) begin
      set_req(tbl[v].id, tbl[v].op, tbl[v].a, tbl[v].b);
      req_valid = 4'(1) << tbl[v].id;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        #1;
        if (req_ready != '0) got = 1'b1;
        else step();
      end
      check("vec_grant_seen", 32'(got), 32'd1);
      check("vec_grant", 32'(req_ready), 32'(req_valid));
      step();
      req_valid = '0;
      #1;
      check("vec_latency_t1", 32'(rsp_valid), 32'd0);
      step();
      #1;
      check("vec_rsp", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word(tbl[v].id, tbl[v].exp));
      step();
    end

    // Round robin from a freshly reset pointer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(10 * i + 1), 8'(i));
    step();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check("rr_grant", 32'(req_ready), 32'(4'(1) << (c % 4)));
      if (c >= 2) check("rr_rsp", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word((c - 2) % 4, rr_data((c - 2) % 4)));
      step();
    end

    // Backpressure: only two entries may be taken while rsp_ready is low.
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (req_ready != '0) ngr++;
      if (c == 2) begin
        held_data = rsp_data;
        held_id   = rsp_id;
      end
      if (c == 4) begin
        check("bp_stable", 32'({rsp_id, rsp_data}), 32'({held_id, held_data}));
        check("bp_hold", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word(0, rr_data(0)));
      end
      step();
    end
    check("bp_grants", 32'(ngr), 32'd2);
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_rsp0", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word(0, rr_data(0)));
    check("bp_resume", 32'(req_ready), 32'(4'b0100));
    step();
    #1;
    check("bp_rel_rsp1", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word(1, rr_data(1)));
    check("bp_resume2", 32'(req_ready), 32'(4'b1000));
    step();
    req_valid = '0;
    #1;
    check("bp_rsp2", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word(2, rr_data(2)));
    step();
    #1;
    check("bp_rsp3", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word(3, rr_data(3)));
    step();

    // Drop en with two entries in flight.
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    check("drain_g0", 32'(req_ready), 32'(4'b0001));
    step();
    en = 1'b0;
    #1;
    check("drain_g1", 32'(req_ready), 32'(4'b0010));
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("drain_no_grant", 32'({busy, req_ready}), 32'({1'b1, 4'b0000}));
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("drain_rsp0", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word(0, rr_data(0)));
    step();
    #1;
    check("drain_rsp1", 32'({rsp_valid, rsp_id, rsp_data}), rsp_word(1, rr_data(1)));
    check("drain_ready", 32'(req_ready), 32'd0);
    step();
    #1;
    check("drain_empty_busy", 32'({rsp_valid, busy}), 32'({1'b0, 1'b1}));
    step();
    #1;
    check("drain_idle", 32'(busy), 32'd0);
    req_valid = '0;
    step();

    // Reset with both stages full, pointer parked away from zero.
    en = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    step();
    step();
    step();
    #1;
    check("rst_pre_full", 32'({rsp_valid, req_ready}), 32'({1'b1, 4'b0000}));
    rst = 1'b1;
    #1;
    check("rst_async", 32'({rsp_valid, busy, req_ready}), 32'd0);
    step();
    rst = 1'b0;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    step();
    #1;
    check("rst_first_grant", 32'(req_ready), 32'(4'b0010));
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_share_arb.md
# add_share_arb

Shares one registered 8-bit add/pass datapath between N_REQ requesters. Each requester presents operands and an op select on a valid/ready handshake. A round-robin arbiter grants one request per cycle into a two-stage pipeline: stage 1 computes the result, stage 2 holds it for output. Results return on a single response port tagged with the requester id. The block sits between the requester blocks and the response consumer, and replaces per-requester adder copies.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 8, operand/result width
- IDW, $clog2(N_REQ), requester id width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  1 = accept new requests; 0 = stop granting and drain
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant; a transfer occurs when valid and ready are both 1
- req_op  in  N_REQ  per-requester op: 1 = add a+b, 0 = pass a
- req_a  in  N_REQ*W  packed operand a, requester i at bits [i*W +: W]
- req_b  in  N_REQ*W  packed operand b, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  requester id of the response
- rsp_data  out  W  result
- busy  out  1  state != IDLE or any pipeline stage full

## Operation
- FSM states and transitions:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> IDLE when both stages are empty.
  - DRAIN -> RUN when en=1 again.
- Grants are issued only in RUN.
- At most one req_ready bit is 1 in any cycle. req_ready[i] = (state==RUN) & req_valid[i] & (i is the first valid index at or after rr_ptr, wrapping) & advance.
- advance = !s1_full | !s2_full | rsp_ready.
- rr_ptr updates to (granted index + 1) mod N_REQ on each transfer. With no transfer, rr_ptr holds. rr_ptr resets to 0.
- Stage 1 latches id, and data = op ? (a+b) : a. Normal-mode add wraps modulo 2^W.
- Stage 2 is the output register: rsp_valid = s2_full; rsp_id and rsp_data come from stage 2.
- Pipeline stalls as a unit:
  - If s2_full & !rsp_ready, stage 2 holds.
  - Stage 1 moves to stage 2 only when stage 2 is empty or being consumed.
  - Stage 1 holds otherwise.
- Responses leave in grant order. No reordering, no drops, no duplicates.
- Reset values: state=IDLE, rr_ptr=0, s1_full=s2_full=0, rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, busy=0.
- Reset mid-operation clears all in-flight entries without producing a response. Requesters reissue after reset.

## Timing
- Latency: transfer in cycle T -> rsp_valid in cycle T+2, provided rsp_ready was 1 throughout.
- Throughput: one response per cycle sustained while rsp_ready=1.
- Back-to-back grants to the same requester are allowed only when no other requester is valid.
- rsp_ready low for k cycles:
  - At most 2 entries are held.
  - Grants stop once both stages are full.
  - Nothing is lost.
- en falls in cycle T:
  - No grant in cycle T+1 or later.
  - In-flight results still complete.
  - busy stays 1 until the last response is accepted, then the FSM enters IDLE the next cycle.
- rsp_data/rsp_id stay stable while rsp_valid=1 and rsp_ready=0.

## Configuration
- ADD_SHARE_ARB_SAT_EN defined: add results saturate, so a+b > 2^W-1 yields 2^W-1 (for W=8: 8'hFF). Pass op is unaffected.
- ADD_SHARE_ARB_SAT_EN undefined: add wraps modulo 2^W (for W=8: 200+100 -> 44).

## Structure
- Shared package add_share_pkg:
  - FSM state typedef: IDLE, RUN, DRAIN.
  - Default W and N_REQ localparams.
  - Pipeline entry struct: id and data.
- Sub-module rr_arbiter (N_REQ): inputs are the request vector, rr_ptr and advance. Outputs are the one-hot grant and the encoded index. It is combinational; the pointer register lives in the parent.

## Test plan
- Single request, requester 2, op=1, a=3, b=4, en=1, rsp_ready=1 -> rsp_valid two cycles after the transfer, rsp_id=2, rsp_data=7; busy returns to 0 after en drops.
- All 4 requesters valid for 8 cycles, rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; responses appear in the same order, one per cycle.
- Wrap/saturate, a=200, b=100, op=1 -> rsp_data=44 without ADD_SHARE_ARB_SAT_EN, 255 with it. Pass op, a=200, op=0 -> 200.
- rsp_ready held 0 for 5 cycles with all requesters valid -> exactly 2 grants occur; rsp_data stays stable; after release the 2 responses arrive in order, then grants resume.
- en dropped with 2 entries in flight -> no further req_ready; both responses arrive; FSM goes DRAIN -> IDLE; busy=0.
- rst asserted while both stages are full -> next cycle rsp_valid=0, busy=0, rr_ptr=0; after release, the first grant goes to the lowest valid index.
